// File: rtl/sm4_axis_blk_pack.sv
// sm4_axis_blk_pack
// Packs an 8-bit AXI-Stream packet into 128-bit SM4 blocks. The first byte of a
// block lands in [127:120]. A final partial block is either PKCS#7 padded
// (PAD_EN=1) or zero-filled (PAD_EN=0). With PAD_EN=1, a packet whose length
// is a multiple of 16 is followed by an extra block of sixteen 0x10 bytes.
//
// Ports:
//   clk, rst        - rising-edge clock, asynchronous active-high reset
//   s_axis_*        - byte input (tdata/tvalid/tready/tlast/tuser)
//   m_blk_data      - assembled block, first byte in [127:120]
//   m_blk_valid     - block valid, held until m_blk_ready
//   m_blk_ready     - downstream accepts block
//   m_blk_last      - final block of the packet
//   m_blk_user      - tuser tag sampled on the first byte of the packet
//   m_blk_nbytes    - payload bytes in the block (pad bytes excluded)
module sm4_axis_blk_pack #(
    parameter int PAD_EN = 1,
    parameter int USER_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic              s_axis_tlast,
    input  logic [USER_W-1:0] s_axis_tuser,
    output logic [127:0]      m_blk_data,
    output logic              m_blk_valid,
    input  logic              m_blk_ready,
    output logic              m_blk_last,
    output logic [USER_W-1:0] m_blk_user,
    output logic [4:0]        m_blk_nbytes
);

    typedef enum logic [1:0] {FILL, HOLD, PADBLK} state_t;

    state_t            state_reg, state_next;
    logic [3:0]        cnt_reg, cnt_next;
    logic [127:0]      data_reg, data_next;
    logic [USER_W-1:0] user_reg, user_next;
    logic [4:0]        nbytes_reg, nbytes_next;
    logic              last_reg, last_next;
    logic              pad_flag_reg, pad_flag_next;
    logic              first_reg, first_next;  // next accepted byte starts a packet

    logic [7:0]        pad_byte;
    logic [127:0]      lane_fill;

    // Pad value for the tail of a partial last block: 16 - (cnt+1) = 15 - cnt.
    assign pad_byte = (PAD_EN != 0) ? (8'd15 - {4'd0, cnt_reg}) : 8'd0;

    // Block image after accepting the current byte: the byte goes into lane
    // cnt; if it carries tlast, every lane after it takes the pad value so a
    // stale tail from the previous block never leaks out.
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_lane
            assign lane_fill[127-8*gi -: 8] =
                (4'(gi) == cnt_reg)                  ? s_axis_tdata :
                (s_axis_tlast && (4'(gi) > cnt_reg)) ? pad_byte     :
                                                       data_reg[127-8*gi -: 8];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= FILL;
            cnt_reg      <= 4'd0;
            data_reg     <= 128'd0;
            user_reg     <= '0;
            nbytes_reg   <= 5'd0;
            last_reg     <= 1'b0;
            pad_flag_reg <= 1'b0;
            first_reg    <= 1'b1;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            data_reg     <= data_next;
            user_reg     <= user_next;
            nbytes_reg   <= nbytes_next;
            last_reg     <= last_next;
            pad_flag_reg <= pad_flag_next;
            first_reg    <= first_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        data_next     = data_reg;
        user_next     = user_reg;
        nbytes_next   = nbytes_reg;
        last_next     = last_reg;
        pad_flag_next = pad_flag_reg;
        first_next    = first_reg;

        case (state_reg)
            FILL: begin
                if (s_axis_tvalid) begin
                    data_next  = lane_fill;
                    cnt_next   = cnt_reg + 4'd1;
                    first_next = s_axis_tlast;
                    if (first_reg) begin
                        user_next = s_axis_tuser;
                    end
                    if ((cnt_reg == 4'd15) || s_axis_tlast) begin
                        state_next    = HOLD;
                        cnt_next      = 4'd0;
                        nbytes_next   = {1'b0, cnt_reg} + 5'd1;
                        // An exactly-full last block under PKCS#7 still needs
                        // the trailing all-0x10 block, which then carries last.
                        pad_flag_next = (PAD_EN != 0) && s_axis_tlast && (cnt_reg == 4'd15);
                        last_next     = s_axis_tlast && !((PAD_EN != 0) && (cnt_reg == 4'd15));
                    end
                end
            end
            HOLD: begin
                if (m_blk_ready) begin
                    if (pad_flag_reg) begin
                        state_next    = PADBLK;
                        data_next     = {16{8'h10}};
                        nbytes_next   = 5'd0;
                        last_next     = 1'b1;
                        pad_flag_next = 1'b0;
                    end else begin
                        state_next = FILL;
                    end
                end
            end
            PADBLK: begin
                if (m_blk_ready) begin
                    state_next = FILL;
                end
            end
            default: begin
                state_next = FILL;
            end
        endcase
    end

    assign s_axis_tready = (state_reg == FILL);
    assign m_blk_valid   = (state_reg != FILL);
    assign m_blk_data    = data_reg;
    assign m_blk_user    = user_reg;
    assign m_blk_nbytes  = nbytes_reg;
    assign m_blk_last    = last_reg;

endmodule
